mc_controller: RTL and testbench

//  Multicycle ARM control unit. Sequences every instruction through FETCH/DECODE/execute states.

---
 rtl/mc_controller_pkg.sv | 71 +++++++
 rtl/mc_controller_if.sv | 40 ++++
 rtl/mc_controller_cond_check.sv | 38 +++
 rtl/mc_controller.sv | 145 ++++++++++++++
 tb/tb_mc_controller.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
// ---------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared encodings for the multicycle ARM control unit and its datapath:
// FSM state enum, Op classes, mux select codes, ALU control codes, and the
// data-processing cmd decoder used by the controller.
// ---------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWR,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    // Instruction classes (Instr[27:26]); also the ImmSrc encoding
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef struct packed {
        logic [1:0] alu_control;
        logic       no_write;   // result is not written back
        logic       arith;      // C/V flags are meaningful
    } alu_dec_t;

    // Unsupported commands compute ADD but suppress write-back.
    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{alu_control: ALU_ADD, no_write: 1'b1, arith: 1'b0};
        case (cmd)
            CMD_ADD: d = '{alu_control: ALU_ADD, no_write: 1'b0, arith: 1'b1};
            CMD_SUB: d = '{alu_control: ALU_SUB, no_write: 1'b0, arith: 1'b1};
            CMD_AND: d = '{alu_control: ALU_AND, no_write: 1'b0, arith: 1'b0};
            CMD_ORR: d = '{alu_control: ALU_ORR, no_write: 1'b0, arith: 1'b0};
            CMD_CMP: d = '{alu_control: ALU_SUB, no_write: 1'b1, arith: 1'b1};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// ---------------------------------------------------------------------------
// mc_controller_if
// Bundle between the control unit (master) and the datapath/memory (slave).
//   Cond/Op/Funct/Rd : instruction fields from the instruction register
//   ALUFlags         : NZCV from the ALU
//   mem_ready        : memory access completes this cycle
//   remaining signals: control outputs driven by the controller
// ---------------------------------------------------------------------------
interface mc_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       mem_ready;

    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags, mem_ready,
        output IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags, mem_ready,
        input  IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );
endinterface

// File: rtl/mc_controller_cond_check.sv
// ---------------------------------------------------------------------------
// cond_check
// ARM condition-field evaluation.
//   cond    in  4  Instr[31:28]
//   flags   in  4  NZCV
//   cond_ex out 1  instruction executes
// Code 1111 is treated as "never".
// ---------------------------------------------------------------------------
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multicycle ARM control unit: FETCH/DECODE/execute sequencing, datapath
// selects, NZCV flag register and condition evaluation, memory stalls.
//   clk     in  single clock, rising edge
//   reset_n in  asynchronous active-low reset
//   bus     mc_controller_if.master (instruction fields, flags, mem_ready
//           in; control selects and write enables out)
// ---------------------------------------------------------------------------
module mc_controller
    import arm_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    mc_controller_if.master   bus
);
    state_t     state_reg, state_next;
    logic [3:0] flags_reg;
    logic       condex_reg;
    logic       cond_ex;
    alu_dec_t   alu_dec;
    logic       in_exec;

    logic       ir_write, pc_write, reg_write, mem_write, wb_en;

    cond_check u_cond_check (
        .cond    (bus.Cond),
        .flags   (flags_reg),
        .cond_ex (cond_ex)
    );

    assign alu_dec = alu_decode(bus.Funct[4:1]);
    assign in_exec = (state_reg == S_EXECR) || (state_reg == S_EXECI);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= S_FETCH;
        else          state_reg <= state_next;
    end

    // Condition latch and flags; flags update on the edge leaving EXECR/EXECI
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_reg  <= 4'b0000;
            condex_reg <= 1'b0;
        end else begin
            if (state_reg == S_DECODE) condex_reg <= cond_ex;
            if (in_exec && condex_reg && bus.Funct[0]) begin
                flags_reg[3:2] <= bus.ALUFlags[3:2];
                if (alu_dec.arith) flags_reg[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = bus.Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_next = S_FETCH;
            S_MEMWB:  state_next = S_FETCH;
            S_EXECR:  state_next = S_ALUWB;
            S_EXECI:  state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        wb_en         = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_RD1;
        bus.ALUSrcB   = SRCB_RD2;
        case (state_reg)
            S_FETCH: begin
                ir_write      = bus.mem_ready;
                pc_write      = bus.mem_ready;
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: bus.ALUSrcB = SRCB_IMM;
            S_MEMRD:  bus.AdrSrc  = 1'b1;
            S_MEMWR: begin
                bus.AdrSrc = 1'b1;
                mem_write  = condex_reg;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                wb_en         = condex_reg;
            end
            S_EXECR:  bus.ALUSrcB = SRCB_RD2;
            S_EXECI:  bus.ALUSrcB = SRCB_IMM;
            S_ALUWB: begin
                bus.ResultSrc = RES_ALUOUT;
                wb_en         = condex_reg & ~alu_dec.no_write;
            end
            S_BRANCH: begin
                bus.ALUSrcA   = SRCA_ALUOUT;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALURESULT;
                pc_write      = condex_reg;
            end
            default: ;
        endcase
        // A write-back to R15 is a jump: steer it to the PC, never both
        if (wb_en) begin
            if (bus.Rd == 4'hF) pc_write  = 1'b1;
            else                reg_write = 1'b1;
        end
    end

    // Write enables are forced low for as long as reset is held
    assign bus.IRWrite  = ir_write  & reset_n;
    assign bus.PCWrite  = pc_write  & reset_n;
    assign bus.RegWrite = reg_write & reset_n;
    assign bus.MemWrite = mem_write & reset_n;

    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
    assign bus.ALUControl = in_exec ? alu_dec.alu_control : ALU_ADD;

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
// Directed instruction sequences against mc_controller with hand-computed
// expected states, selects, write enables and flags.
// ---------------------------------------------------------------------------
module tb_mc_controller;
    import arm_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_bad   = 0;

    mc_controller_if bus ();

    mc_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins);
        bus.Cond  = ins[31:28];
        bus.Op    = ins[27:26];
        bus.Funct = ins[25:20];
        bus.Rd    = ins[15:12];
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check_val(tag, 32'(dut.state_reg), 32'(exp));
    endtask

    // Data-processing instruction from FETCH back to FETCH (immediate form)
    task automatic run_dp(input logic [31:0] ins, input logic [3:0] alu_flags,
                          input logic [1:0] exp_alu, input logic exp_rw,
                          input logic exp_pcw, input logic [3:0] exp_flags);
        set_instr(ins);
        #1;
        check_state("dp_fetch", S_FETCH);
        tick;
        check_state("dp_decode", S_DECODE);
        check_val("dp_decode_regwrite", 32'(bus.RegWrite), 32'(0));
        tick;
        check_state("dp_exec", S_EXECI);
        check_val("dp_exec_srcb", 32'(bus.ALUSrcB), 32'(2'b01));
        check_val("dp_exec_alucontrol", 32'(bus.ALUControl), 32'(exp_alu));
        check_val("dp_exec_regwrite", 32'(bus.RegWrite), 32'(0));
        bus.ALUFlags = alu_flags;
        tick;
        check_state("dp_aluwb", S_ALUWB);
        check_val("dp_aluwb_regwrite", 32'(bus.RegWrite), 32'(exp_rw));
        check_val("dp_aluwb_pcwrite", 32'(bus.PCWrite), 32'(exp_pcw));
        check_val("dp_flags", 32'(dut.flags_reg), 32'(exp_flags));
        tick;
        check_state("dp_done", S_FETCH);
        $display("instr %08h dp done", ins);
    endtask

    task automatic run_br(input logic [31:0] ins, input logic exp_pcw);
        set_instr(ins);
        #1;
        check_val("br_immsrc", 32'(bus.ImmSrc), 32'(2'b10));
        check_val("br_regsrc", 32'(bus.RegSrc), 32'(2'b01));
        tick;
        check_state("br_decode", S_DECODE);
        tick;
        check_state("br_branch", S_BRANCH);
        check_val("br_srca", 32'(bus.ALUSrcA), 32'(2'b10));
        check_val("br_pcwrite", 32'(bus.PCWrite), 32'(exp_pcw));
        tick;
        check_state("br_done", S_FETCH);
        $display("instr %08h branch done", ins);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.ALUFlags  = 4'b0000;
        set_instr(32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_state("rst_state", S_FETCH);
        check_val("rst_irwrite", 32'(bus.IRWrite), 32'(0));
        check_val("rst_pcwrite", 32'(bus.PCWrite), 32'(0));
        check_val("rst_flags", 32'(dut.flags_reg), 32'(0));
        reset_n = 1'b1;
        $display("reset released");

        // ADD R1,R2,#5
        set_instr(32'hE2821005);
        #1;
        check_val("add_irwrite", 32'(bus.IRWrite), 32'(1));
        check_val("add_immsrc", 32'(bus.ImmSrc), 32'(2'b00));
        run_dp(32'hE2821005, 4'b1111, 2'b00, 1'b1, 1'b0, 4'b0000);

        // LDR R1,[R2] with three stalled MEMRD cycles
        set_instr(32'hE5921000);
        tick;
        check_state("ldr_decode", S_DECODE);
        tick;
        check_state("ldr_memadr", S_MEMADR);
        check_val("ldr_memadr_srcb", 32'(bus.ALUSrcB), 32'(2'b01));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_state("ldr_memrd_hold", S_MEMRD);
            check_val("ldr_memrd_adrsrc", 32'(bus.AdrSrc), 32'(1));
            check_val("ldr_memrd_regwrite", 32'(bus.RegWrite), 32'(0));
        end
        bus.mem_ready = 1'b1;
        tick;
        check_state("ldr_memwb", S_MEMWB);
        check_val("ldr_memwb_regwrite", 32'(bus.RegWrite), 32'(1));
        check_val("ldr_memwb_resultsrc", 32'(bus.ResultSrc), 32'(2'b01));
        tick;
        check_state("ldr_done", S_FETCH);
        check_val("ldr_done_regwrite", 32'(bus.RegWrite), 32'(0));
        $display("instr e5921000 ldr done");

        // SUBS with Z=1, then BEQ taken
        run_dp(32'hE2521001, 4'b0100, 2'b01, 1'b1, 1'b0, 4'b0100);
        run_br(32'h0A000001, 1'b1);
        // SUBS with Z=0 C=1, then BEQ not taken
        run_dp(32'hE2521001, 4'b0010, 2'b01, 1'b1, 1'b0, 4'b0010);
        run_br(32'h0A000001, 1'b0);
        // ADDEQS with Z=0: no write, flags unchanged
        run_dp(32'h02921005, 4'b1111, 2'b00, 1'b0, 1'b0, 4'b0010);

        // Op=11: DECODE then straight back to FETCH
        set_instr(32'hEC000000);
        tick;
        check_state("op11_decode", S_DECODE);
        check_val("op11_we", 32'({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite}), 32'(0));
        tick;
        check_state("op11_done", S_FETCH);
        $display("instr ec000000 op11 done");

        // ADD R15,R2,#0: write-back goes to the PC
        run_dp(32'hE282F000, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0010);

        // STR stalled in MEMWR, reset asserted mid-access
        set_instr(32'hE5821000);
        tick;
        tick;
        check_state("str_memadr", S_MEMADR);
        bus.mem_ready = 1'b0;
        tick;
        check_state("str_memwr", S_MEMWR);
        check_val("str_memwrite", 32'(bus.MemWrite), 32'(1));
        check_val("str_adrsrc", 32'(bus.AdrSrc), 32'(1));
        reset_n = 1'b0;
        #1;
        check_val("str_rst_memwrite", 32'(bus.MemWrite), 32'(0));
        check_state("str_rst_state", S_FETCH);
        check_val("str_rst_flags", 32'(dut.flags_reg), 32'(0));
        bus.mem_ready = 1'b1;
        #1;
        check_val("str_rst_irwrite", 32'(bus.IRWrite), 32'(0));
        tick;
        reset_n = 1'b1;
        #1;
        check_val("post_rst_irwrite", 32'(bus.IRWrite), 32'(1));
        tick;
        check_state("post_rst_decode", S_DECODE);
        $display("instr e5821000 str aborted by reset");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
